// File: rtl/stl_rr_pkg.sv
// Shared types and helpers for the round-robin multi-pick arbiter: scan direction,
// modulo-n stepping that works for any n, and a population count.
package stl_rr_pkg;

    typedef enum logic {
        SCAN_INC = 1'b0,
        SCAN_DEC = 1'b1
    } scan_dir_e;

    localparam int unsigned POPCNT_MAX_W = 256;

    // Explicit compare-and-wrap so non-power-of-2 requester counts step correctly.
    function automatic int unsigned wrap_inc(input int unsigned pos, input int unsigned n);
        return (pos + 1 >= n) ? 0 : pos + 1;
    endfunction

    function automatic int unsigned wrap_dec(input int unsigned pos, input int unsigned n);
        return (pos == 0) ? n - 1 : pos - 1;
    endfunction

    function automatic int unsigned popcnt(input logic [POPCNT_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POPCNT_MAX_W; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/stl_rr_pick_comb.sv
// Combinational round-robin finder: walks REQ_N positions from ptr in the given
// direction and returns the first GNT_M requesters as packed slots plus a grant one-hot.
module stl_rr_pick_comb
    import stl_rr_pkg::*;
#(
    parameter  int REQ_N = 16,
    parameter  int GNT_M = 2,
    localparam int POS_W = $clog2(REQ_N)
) (
    input  logic [REQ_N-1:0]       req,
    input  logic [POS_W-1:0]       ptr,
    input  scan_dir_e              dir,
    output logic [GNT_M-1:0]       slot_vld,
    output logic [GNT_M*POS_W-1:0] slot_pos,
    output logic [REQ_N-1:0]       gnt
);

    always_comb begin : find
        logic [POS_W-1:0] idx;
        int               taken;
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        slot_vld = '0;
        slot_pos = '0;
        gnt      = '0;
        idx      = ptr;
        taken    = 0;
        for (int k = 0; k < REQ_N; k++) begin
            if (req[idx] && taken < GNT_M) begin
                for (int s = 0; s < GNT_M; s++) begin
                    if (s == taken) begin
                        slot_vld[s]                  = 1'b1;
                        slot_pos[s*POS_W +: POS_W]   = idx;
                    end
                end
                gnt[idx] = 1'b1;
                taken    = taken + 1;
            end
            idx = (dir == SCAN_INC) ? POS_W'(wrap_inc(32'(idx), REQ_N))
                                    : POS_W'(wrap_dec(32'(idx), REQ_N));
        end
    end

endmodule

// File: rtl/stl_rr_multi_pick.sv
// Round-robin multi-grant picker with payload mux, registered valid/ready output stage
// and self-updating scan pointer. Optional macro STL_RR_MULTI_PICK_HOLD_EN adds ptr_hold_i.
module stl_rr_multi_pick
    import stl_rr_pkg::*;
#(
    parameter  int REQ_N  = 16,
    parameter  int DATA_W = 32,
    parameter  int GNT_M  = 2,
    parameter  int TYPE   = 0,
    localparam int POS_W  = $clog2(REQ_N),
    localparam int CNT_W  = $clog2(GNT_M + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REQ_N-1:0]        req_i,
    input  logic [REQ_N*DATA_W-1:0] req_data_i,
    input  logic                    out_rdy_i,
`ifdef STL_RR_MULTI_PICK_HOLD_EN
    input  logic                    ptr_hold_i,
`endif
    output logic [GNT_M-1:0]        out_vld_o,
    output logic [GNT_M*POS_W-1:0]  out_pos_o,
    output logic [GNT_M*DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]        out_cnt_o,
    output logic [REQ_N-1:0]        gnt_o,
    output logic [POS_W-1:0]        ptr_o
);

    localparam scan_dir_e DIR = (TYPE == 0) ? SCAN_INC : SCAN_DEC;

    logic [GNT_M-1:0]        pick_vld;
    logic [GNT_M*POS_W-1:0]  pick_pos;
    logic [REQ_N-1:0]        pick_gnt;
    logic [GNT_M*DATA_W-1:0] pick_data;
    logic [POS_W-1:0]        last_pos;
    logic [POS_W-1:0]        next_ptr;
    logic [POS_W-1:0]        ptr_q;
    logic                    load;
    logic                    ptr_upd;

    stl_rr_pick_comb #(
        .REQ_N (REQ_N),
        .GNT_M (GNT_M)
    ) u_pick (
        .req      (req_i),
        .ptr      (ptr_q),
        .dir      (DIR),
        .slot_vld (pick_vld),
        .slot_pos (pick_pos),
        .gnt      (pick_gnt)
    );

    // A stalled stage freezes everything; an empty stage always accepts.
    assign load  = ~(|out_vld_o) | out_rdy_i;
    assign gnt_o = (load && !rst) ? pick_gnt : '0;
    assign ptr_o = ptr_q;

`ifdef STL_RR_MULTI_PICK_HOLD_EN
    assign ptr_upd = (|pick_vld) && !ptr_hold_i;
`else
    assign ptr_upd = |pick_vld;
`endif

    always_comb begin
        pick_data = '0;
        last_pos  = '0;
        for (int s = 0; s < GNT_M; s++) begin
            for (int j = 0; j < REQ_N; j++) begin
                if (pick_vld[s] && pick_pos[s*POS_W +: POS_W] == POS_W'(j)) begin
                    pick_data[s*DATA_W +: DATA_W] = req_data_i[j*DATA_W +: DATA_W];
                end
            end
            if (pick_vld[s]) begin
                last_pos = pick_pos[s*POS_W +: POS_W];
            end
        end
        next_ptr = (DIR == SCAN_INC) ? POS_W'(wrap_inc(32'(last_pos), REQ_N))
                                     : POS_W'(wrap_dec(32'(last_pos), REQ_N));
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_o  <= '0;
            out_pos_o  <= '0;
            out_data_o <= '0;
            out_cnt_o  <= '0;
            ptr_q      <= '0;
        end else if (load) begin
            out_vld_o  <= pick_vld;
            out_pos_o  <= pick_pos;
            out_data_o <= pick_data;
            out_cnt_o  <= CNT_W'(popcnt(POPCNT_MAX_W'(pick_vld)));
            if (ptr_upd) begin
                ptr_q <= next_ptr;
            end
        end
    end

endmodule
